pooling_window_max: RTL
=======================

# pooling_window_max

Streaming, parametrised max-pooling engine for the pooling layer.
- Accepts a channel-interleaved IEEE-754 single-precision feature-map stream from the convolution stage and emits one pooled value per channel per non-overlapping POOL_K×POOL_K window.
- Optional fused ReLU on the result.
- Valid/ready handshake on both sides, so it sits between the convolution output FIFO and the next layer's input buffer.

## Interface
- DATA_WIDTH, 32, sample width (IEEE-754 single).
- CHANNELS, 4, feature maps interleaved per pixel.
- IMG_W, 8, input row length in pixels; must be a multiple of POOL_K.
- IMG_H, 8, input rows per frame; must be a multiple of POOL_K.
- POOL_K, 2, window size and stride; must be ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous frame abort; dominates every other input.
- relu_en  in  1  clamp negative results to +0.0; sampled per output.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  DATA_WIDTH  pixel sample.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  pooled value.
- out_ch  out  $clog2(CHANNELS)  channel of out_data.
- out_last  out  1  final result of the frame.
- busy  out  1  frame in progress (any counter non-zero, or out_valid).

## Operation
- **Input order:** row-major. Each pixel is CHANNELS consecutive beats, ch 0 first.
- **Counters:** ch_cnt, col_cnt (0..IMG_W-1) and row_cnt (0..IMG_H-1) advance only on accept (in_valid && in_ready). All wrap to 0 after the last beat of the frame; the next beat starts a new frame with no idle cycle required.
- **Partial-max buffer:**
  - IMG_W/POOL_K×CHANNELS entries, DATA_WIDTH each.
  - Address = (col_cnt/POOL_K)×CHANNELS + ch_cnt.
  - Asynchronous read, written on accept.
- **Window update per accepted beat:**
  - First beat of a window (row_cnt%POOL_K==0 and col_cnt%POOL_K==0): write in_data directly. No clear pass is needed, and stale data from earlier frames is never used.
  - Otherwise: write fp_max(entry, in_data).
- **Window close:** a beat closes its window when row_cnt%POOL_K==POOL_K-1 and col_cnt%POOL_K==POOL_K-1. On that beat the max result is loaded into the output register instead, with:
  - out_ch = ch_cnt.
  - out_last = last beat of the frame.
  - ReLU applied if relu_en: sign=1 → 32'h0000_0000.
- **fp_max rules:**
  - Sign-magnitude compare.
  - -0.0 and +0.0 are equal.
  - On a tie, the stored value is kept.
  - NaN/Inf inputs are unsupported, and their result is unspecified.
- **clear:**
  - Zeroes counters.
  - Drops out_valid and out_last.
  - Forces in_ready low for that cycle.
  - The next accepted beat is pixel (0,0) ch 0.
- **Reset:** counters, out_valid, out_data, out_ch and out_last are all 0; buffer contents are don't-care.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0.
- **Latency:** out_valid is asserted the cycle after the window-closing beat is accepted.
- **Backpressure:**
  - in_ready = !out_valid || out_ready (single output register; full throughput when out_ready is held high).
  - in_ready may only depend combinationally on out_ready and internal state, never on in_valid.
- **Output hold:** out_valid, out_data, out_ch and out_last stay stable while out_valid && !out_ready.
- **Simultaneous drain and load:** when a result is accepted and a new one is loaded in the same cycle, the new result appears with no bubble.
- **Peak rate:** CHANNELS consecutive results, one per cycle, at each window-closing pixel.
- **Reset mid-frame:** output is lost and the next frame starts cleanly; there is no partial output.

## Structure
- **Package pooling_pkg:**
  - DATA_WIDTH default.
  - fp32 field typedef (sign, exp[7:0], man[22:0]).
  - FP_POS_ZERO constant.
- **Sub-module fp_max_cmp:** combinational a/b → max, implementing the compare rules above. The ReLU clamp is done in the top level.
- **Top level:** counter/window-position logic, buffer array, output register and handshake.

## Test plan
- **Ramp frame:** defaults; in_data = float(beat_index) for beats 0..255; out_ready=1 → 64 outputs. Window (wr,wc) ch c equals float((2wr+1)·32 + (2wc+1)·4 + c), i.e. pixel (2wr+1, 2wc+1); out_last only on output 63.
- **ReLU:**
  - All inputs -3.5 with relu_en=0 → every output 32'hC060_0000.
  - Same frame with relu_en=1 → every output 32'h0000_0000.
  - Mixed window {-1.0, -0.0, +0.0, -2.0} with relu_en=0 → ±0.0, first stored value kept.
- **Backpressure:** random in_valid; out_ready low for 5 cycles at output 3 → in_ready low while blocked, out_data stable, all 64 results in order with none lost or duplicated.
- **Back-to-back frames:** frame 1 all 100.0, frame 2 all 1.0, no gap → frame 2 outputs are all 1.0, proving no stale maxima.
- **Abort:**
  - clear after 37 beats, then a full ramp frame → exactly 64 correct outputs.
  - Repeat using rst_n asserted mid-frame → same result.
- **Parameter variant:** POOL_K=3, IMG_W=IMG_H=6, CHANNELS=1; max placed at a different window position per window → 4 outputs equal to the planted maxima.

Source files
------------

// File: rtl/pooling_pkg.sv
// rtl/pooling_pkg.sv - shared types and constants for the max-pooling engine
package pooling_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_max_cmp.sv
// rtl/fp_max_cmp.sv - combinational IEEE-754 single max, keeps a on ties
module fp_max_cmp
    import pooling_pkg::*;
(
    input  logic [DEFAULT_DATA_WIDTH-1:0] a,
    input  logic [DEFAULT_DATA_WIDTH-1:0] b,
    output logic [DEFAULT_DATA_WIDTH-1:0] max
);

    fp32_t fa;
    fp32_t fb;
    logic  b_gt;

    always_comb begin
        fa   = fp32_t'(a);
        fb   = fp32_t'(b);
        b_gt = 1'b0;
        // Both zeros compare equal regardless of sign, so the stored value wins.
        if ({fa.exp, fa.man} == '0 && {fb.exp, fb.man} == '0) begin
            b_gt = 1'b0;
        end else if (fa.sign != fb.sign) begin
            b_gt = !fb.sign;
        end else if (!fa.sign) begin
            b_gt = {fb.exp, fb.man} > {fa.exp, fa.man};
        end else begin
            b_gt = {fb.exp, fb.man} < {fa.exp, fa.man};
        end
        max = b_gt ? b : a;
    end

endmodule

// File: rtl/pooling_window_max.sv
// rtl/pooling_window_max.sv - streaming POOL_K x POOL_K max pooling with optional ReLU
module pooling_window_max
    import pooling_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = 4,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int POOL_K     = 2,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_last,
    output logic                  busy
);

    localparam int NWIN  = IMG_W / POOL_K;
    localparam int DEPTH = NWIN * CHANNELS;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int K_W   = $clog2(POOL_K);
    localparam int WC_W  = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    // kx/ky track position inside the window, wcol the window column; avoids modulo/divide.
    logic [K_W-1:0]   kx;
    logic [K_W-1:0]   ky;
    logic [WC_W-1:0]  wcol;

    logic [DATA_WIDTH-1:0] win_buf [DEPTH];
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] cmp_max;
    logic [DATA_WIDTH-1:0] upd;
    logic [DATA_WIDTH-1:0] result;

    logic accept, ch_last, col_last, row_last, kx_last, ky_last;
    logic win_first, win_close, frame_last;

    assign in_ready   = (!out_valid || out_ready) && !clear;
    assign accept     = in_valid && in_ready;
    assign ch_last    = ch_cnt == CH_W'(CHANNELS - 1);
    assign col_last   = col_cnt == COL_W'(IMG_W - 1);
    assign row_last   = row_cnt == ROW_W'(IMG_H - 1);
    assign kx_last    = kx == K_W'(POOL_K - 1);
    assign ky_last    = ky == K_W'(POOL_K - 1);
    assign win_first  = (kx == '0) && (ky == '0);
    assign win_close  = kx_last && ky_last;
    assign frame_last = ch_last && col_last && row_last;
    assign addr       = AW'(int'(wcol) * CHANNELS + int'(ch_cnt));
    assign busy       = (ch_cnt != '0) || (col_cnt != '0) || (row_cnt != '0) || out_valid;

    fp_max_cmp u_cmp (
        .a   (win_buf[addr]),
        .b   (in_data),
        .max (cmp_max)
    );

    assign upd    = win_first ? in_data : cmp_max;
    assign result = (relu_en && upd[DATA_WIDTH-1]) ? FP_POS_ZERO : upd;

    always_ff @(posedge clk) begin
        if (accept) begin
            win_buf[addr] <= upd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            kx      <= '0;
            ky      <= '0;
            wcol    <= '0;
        end else if (clear) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            kx      <= '0;
            ky      <= '0;
            wcol    <= '0;
        end else if (accept) begin
            if (ch_last) begin
                ch_cnt <= '0;
                if (col_last) begin
                    col_cnt <= '0;
                    kx      <= '0;
                    wcol    <= '0;
                    if (row_last) begin
                        row_cnt <= '0;
                        ky      <= '0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                        ky      <= ky_last ? '0 : ky + 1'b1;
                    end
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                    kx      <= kx_last ? '0 : kx + 1'b1;
                    if (kx_last) begin
                        wcol <= wcol + 1'b1;
                    end
                end
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept && win_close) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_ch    <= ch_cnt;
            out_last  <= frame_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
